// File: rtl/pipelined_shifter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipelined_shifter                                            |
// | Description : Pipelined multi-mode barrel shifter (SLL/SRL/SRA/ROR, full   |
// |               width or RV64-style word mode) with valid/ready handshake,   |
// |               flush and a pass-through sideband tag.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
//
// Every operation is normalised into a right shift or right rotate of a
// WIDTH-bit word:
//   - SLL is done as bit-reverse, right shift, bit-reverse.
//   - Word ROR duplicates the low half, so a WIDTH-bit rotate by less than
//     WIDTH/2 leaves the half-width rotation in the low half.
//   - Word SRL/SRA pre-fill the upper half with the fill bit.
// The SHAMT_W mux levels, LSB first, are then spread over PIPE_STAGES
// registers. The un-reverse and the word-mode sign extension happen in front
// of the last register, so out_* come straight from flops.
module pipelined_shifter #(
  parameter int WIDTH       = 64,
  parameter int SHAMT_W     = $clog2(WIDTH),
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic               in_word,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int C_HALF  = WIDTH / 2;
  localparam int C_BASE  = SHAMT_W / PIPE_STAGES;
  localparam int C_EXTRA = SHAMT_W % PIPE_STAGES;

  localparam logic [1:0] C_OP_SLL = 2'b00;
  localparam logic [1:0] C_OP_SRA = 2'b10;
  localparam logic [1:0] C_OP_ROR = 2'b11;

  // First mux level owned by stage k; earlier stages take the leftover levels.
  function automatic int first_level(input int k);
    return k * C_BASE + ((k < C_EXTRA) ? k : C_EXTRA);
  endfunction

  function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
    return r;
  endfunction

  // One mux level: right shift by 2**lvl, filling with the wrapped bits or the fill bit.
  function automatic logic [WIDTH-1:0] right_step(input logic [WIDTH-1:0] x, input int lvl,
                                                  input logic rot, input logic fill);
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] ones;
    int               amt;
    amt  = 1 << lvl;
    ones = '1;
    r    = x >> amt;
    if (rot)       r = r | (x << (WIDTH - amt));
    else if (fill) r = r | ~(ones >> amt);
    return r;
  endfunction

  // Stage registers
  logic [WIDTH-1:0]       data_q  [PIPE_STAGES];
  logic [WIDTH-1:0]       data_d  [PIPE_STAGES];
  logic [SHAMT_W-1:0]     shamt_q [PIPE_STAGES];
  logic [SHAMT_W-1:0]     shamt_d [PIPE_STAGES];
  logic [1:0]             op_q    [PIPE_STAGES];
  logic [1:0]             op_d    [PIPE_STAGES];
  logic [TAG_W-1:0]       tag_q   [PIPE_STAGES];
  logic [TAG_W-1:0]       tag_d   [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] word_q, word_d;
  logic [PIPE_STAGES-1:0] fill_q, fill_d;
  logic [PIPE_STAGES-1:0] valid_q, valid_d;
  logic [PIPE_STAGES-1:0] adv;

  // Normalised input operand
  logic [WIDTH-1:0]   pre_data;
  logic [SHAMT_W-1:0] pre_shamt;
  logic               pre_fill;

  // Map every op/mode onto a right shift or rotate of a WIDTH-bit word.
  always_comb begin
    logic [C_HALF-1:0] lo;
    lo        = in_data[C_HALF-1:0];
    pre_shamt = in_shamt;
    pre_fill  = 1'b0;
    if (in_word) pre_shamt[SHAMT_W-1] = 1'b0;
    if (in_op == C_OP_SRA) pre_fill = in_word ? lo[C_HALF-1] : in_data[WIDTH-1];
    if (!in_word)               pre_data = in_data;
    else if (in_op == C_OP_ROR) pre_data = {lo, lo};
    else                        pre_data = {{C_HALF{pre_fill}}, lo};
    if (in_op == C_OP_SLL) pre_data = bit_reverse(pre_data);
  end

  // Stage k advances when it is empty or everything downstream of it advances.
  always_comb begin
    logic downstream;
    downstream = out_ready;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      downstream = !valid_q[k] || downstream;
      adv[k]     = downstream;
    end
  end

  assign in_ready = !flush && adv[0];

  // Next state per stage: shift through this stage's levels on advance, hold on stall, kill valid on flush.
  always_comb begin
    logic [WIDTH-1:0]   v;
    logic [WIDTH-1:0]   s_data;
    logic [SHAMT_W-1:0] s_shamt;
    logic [1:0]         s_op;
    logic [TAG_W-1:0]   s_tag;
    logic               s_word;
    logic               s_fill;
    logic               s_valid;
    int                 p;
    for (int k = 0; k < PIPE_STAGES; k++) begin
      data_d[k]  = data_q[k];
      shamt_d[k] = shamt_q[k];
      op_d[k]    = op_q[k];
      tag_d[k]   = tag_q[k];
      word_d[k]  = word_q[k];
      fill_d[k]  = fill_q[k];
      valid_d[k] = valid_q[k];

      p = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        s_data  = pre_data;
        s_shamt = pre_shamt;
        s_op    = in_op;
        s_tag   = in_tag;
        s_word  = in_word;
        s_fill  = pre_fill;
        s_valid = in_valid;
      end else begin
        s_data  = data_q[p];
        s_shamt = shamt_q[p];
        s_op    = op_q[p];
        s_tag   = tag_q[p];
        s_word  = word_q[p];
        s_fill  = fill_q[p];
        s_valid = valid_q[p];
      end

      v = s_data;
      for (int l = 0; l < SHAMT_W; l++) begin
        if (l >= first_level(k) && l < first_level(k + 1) && s_shamt[l])
          v = right_step(v, l, s_op == C_OP_ROR, s_fill);
      end
      if (k == PIPE_STAGES - 1) begin
        if (s_op == C_OP_SLL) v = bit_reverse(v);
        if (s_word) v = {{C_HALF{v[C_HALF-1]}}, v[C_HALF-1:0]};
      end

      if (flush) begin
        valid_d[k] = 1'b0;
      end else if (adv[k]) begin
        valid_d[k] = s_valid;
        if (s_valid) begin
          data_d[k]  = v;
          shamt_d[k] = s_shamt;
          op_d[k]    = s_op;
          tag_d[k]   = s_tag;
          word_d[k]  = s_word;
          fill_d[k]  = s_fill;
        end
      end
    end
  end

  // Stage registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        op_q[k]    <= '0;
        tag_q[k]   <= '0;
      end
      word_q  <= '0;
      fill_q  <= '0;
      valid_q <= '0;
    end else begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        data_q[k]  <= data_d[k];
        shamt_q[k] <= shamt_d[k];
        op_q[k]    <= op_d[k];
        tag_q[k]   <= tag_d[k];
      end
      word_q  <= word_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q[PIPE_STAGES-1];
  assign out_data  = data_q[PIPE_STAGES-1];
  assign out_tag   = tag_q[PIPE_STAGES-1];

endmodule
`default_nettype wire

// File: doc/pipelined_shifter.md
# pipelined_shifter

Pipelined, multi-mode barrel shifter for the GPU lane ALU. Accepts one operand per cycle under a valid/ready handshake and supports logical left, logical right, arithmetic right and rotate right, plus an RV64 word mode (SLLW/SRLW/SRAW/RORW semantics). It sits between the operand-read stage and the writeback arbiter. A tag carried alongside each operation lets the arbiter route results back to the owning thread.

## Interface
- WIDTH, 64: datapath width; must be a power of two and at least 8.
- SHAMT_W, $clog2(WIDTH): shift-amount width; derived from WIDTH, not overridden.
- PIPE_STAGES, 2: number of register stages, legal range 1..SHAMT_W; this is also the latency in cycles.
- TAG_W, 8: width of the sideband tag passed through unchanged.
- clk, input, 1: clock; all state updates on its rising edge.
- rst, input, 1: reset; asynchronous, active-high.
- flush, input, 1: synchronous pipeline kill.
- in_valid, input, 1: input operation present.
- in_ready, output, 1: the block accepts the input this cycle.
- in_data, input, WIDTH: operand.
- in_shamt, input, SHAMT_W: shift amount.
- in_op, input, 2: operation select; 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_word, input, 1: word mode; operate on the low WIDTH/2 bits.
- in_tag, input, TAG_W: sideband tag.
- out_valid, output, 1: result present.
- out_ready, input, 1: the consumer accepts the result.
- out_data, output, WIDTH: result.
- out_tag, output, TAG_W: tag of the result.

## Operation
- **Transfer rule.** A transfer occurs on any edge where valid && ready is high, on either port.
- **Word mode, amount.** The effective amount is in_shamt[SHAMT_W-2:0]. Bit SHAMT_W-1 is ignored.
- **Word mode, operand.**
  - The operand is in_data[WIDTH/2-1:0].
  - For SRA the operand's fill bit is in_data[WIDTH/2-1].
  - For ROR the rotation wraps within WIDTH/2 bits.
- **Word mode, result.** The WIDTH/2-bit result is sign-extended from its bit WIDTH/2-1 to WIDTH. This applies to all four ops, including SLL and SRL.
- **Full-width mode.** The amount is the full in_shamt.
  - SLL and SRL zero-fill.
  - SRA fills with in_data[WIDTH-1].
  - ROR wraps within WIDTH bits.
- **Shift amount 0.** The operand passes unchanged; in word mode it is still sign-extended.
- **Datapath structure.** The datapath is SHAMT_W binary mux levels, one per shamt bit, LSB level first.
  - The levels are split across PIPE_STAGES register stages.
  - Each stage gets either ceil or floor of SHAMT_W/PIPE_STAGES levels; earlier stages take the extra levels.
  - Each stage register holds: partial result, remaining shamt bits, op, word, fill bit, tag and a valid bit.
  - The last stage register drives out_* directly, so outputs are registered with no combinational path from in_* to out_*.
- **Backpressure.**
  - Stage k advances when it is empty or stage k+1 advances.
  - The last stage advances when it is empty or out_ready is high.
  - in_ready = !flush && (stage 1 empty || stage 1 advances).
  - This gives full throughput of one per cycle with out_ready held high. No bubbles are inserted.
- **Stalled contents.** A stalled stage holds all of its fields. out_data and out_tag stay stable while out_valid && !out_ready.
- **flush.** On the edge with flush=1, all valid bits clear.
  - An input presented that cycle is not accepted, because in_ready=0.
  - Data registers are not cleared.
- **Flush vs. out_ready.** flush takes priority over a simultaneous out_ready. The consumer must ignore an out handshake that coincides with flush.
- **Reset.** All stage registers clear asynchronously: valid=0, data=0, tag=0.

## Timing
- **Latency.** Exactly PIPE_STAGES cycles from the input transfer edge to out_valid=1, when not stalled.
- **Ordering.** Results emerge in acceptance order; there is no reordering.
- **Reset values.** out_valid=0, out_data=0, out_tag=0. in_ready=1 once rst deasserts and flush=0; in_ready is combinational.
- **Reset mid-stream.** Asserting rst while the pipe is full empties it immediately. No result is emitted after rst deasserts.
- **Stall depth.** With out_ready low, the pipe absorbs exactly PIPE_STAGES operations; then in_ready drops to 0.
- **Release.** When out_ready returns to 1, in_ready is 1 in that same cycle because the stages advance.

## Test plan
- **Full-width ops.** Use WIDTH=64 and PIPE_STAGES=2; in_data=64'h8000_0000_0000_0001, shamt=1.
  - SLL -> 64'h0000_0000_0000_0002.
  - SRL -> 64'h4000_0000_0000_0000.
  - SRA -> 64'hC000_0000_0000_0000.
  - ROR -> 64'hC000_0000_0000_0000.
  - Each appears exactly 2 cycles after acceptance.
- **Word mode.** in_data=64'hFFFF_FFFF_0000_0001, word=1, SLL, shamt=6'd63 (effective 31) -> 64'hFFFF_FFFF_8000_0000.
- **Word-mode SRA.** in_data=64'h0000_0000_8000_0000, shamt=4 -> 64'hFFFF_FFFF_F800_0000.
- **Word-mode ROR.** in_data=64'h0000_0000_0000_0001, ROR, shamt=1 -> 64'hFFFF_FFFF_8000_0000.
- **Backpressure.** Stream 6 ops with tags 1..6 while holding out_ready=0.
  - in_ready falls after 2 accepts.
  - Release out_ready -> tags 1..6 emerge in order, with data stable during the stall and no loss or duplication.
- **Flush and reset.** Fill the pipe, then assert flush with in_valid=1 -> in_ready=0, and out_valid=0 on the next cycle. Assert rst mid-stream -> all outputs 0 asynchronously. Run random ops against a reference model for PIPE_STAGES = 1, 3 and 6.
